// File: rtl/uart_pkg.sv
// Shared UART constants and receiver FSM state encoding.
// The transmitter in uart_top uses the same constants.
package uart_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        HOLD  = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for a single asynchronous input.
// The reset value is configurable so idle-high lines do not see a false edge.
module uart_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    generate
        if (STAGES == 1) begin : g_one
            // Single-flop capture of the asynchronous input.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_r <= RESET_VAL;
                end else begin
                    sync_r <= d;
                end
            end
        end else begin : g_multi
            // Shift chain: the input enters at bit 0 and leaves at the MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_r <= {STAGES{RESET_VAL}};
                end else begin
                    sync_r <= {sync_r[STAGES-2:0], d};
                end
            end
        end
    endgenerate

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register and valid/ack handshake.
// Samples each bit at its centre, counted from the synchronized start-bit edge.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rx,
    output logic [UART_DATA_W-1:0] o_rx_data,
    output logic                   o_rx_valid,
    input  logic                   i_rx_ack,
    output logic                   o_frame_err,
    output logic                   o_overrun,
    output logic                   o_busy
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]   HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_MX = FLUSH_W'(SYNC_STAGES);

    logic                   rx_s;
    rx_state_e              state_r, state_next_s;
    logic [CNT_W-1:0]       cnt_r, cnt_next_s;
    logic [2:0]             idx_r, idx_next_s;
    logic [UART_DATA_W-1:0] shift_r, shift_next_s;
    logic [FLUSH_W-1:0]     flush_cnt_r;
    logic                   flushed_s;
    logic                   armed_r;
    logic                   tick_s;
    logic                   good_s;
    logic                   bad_s;
    logic [UART_DATA_W-1:0] data_r, data_next_s;
    logic                   valid_r, valid_next_s;
    logic                   frame_err_r, frame_err_next_s;
    logic                   overrun_r, overrun_next_s;
    logic                   busy_r;

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (i_rx),
        .q     (rx_s)
    );

    // The synchronizer's reset value is not the real line; only trust rx_s
    // after the chain has flushed, and only arm once the line is seen high.
    assign flushed_s = (flush_cnt_r == FLUSH_MX);

    // Flush tracking and start-detect arming after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt_r <= {FLUSH_W{1'b0}};
            armed_r     <= 1'b0;
        end else begin
            if (!flushed_s) begin
                flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
            end
            if (flushed_s && rx_s) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Sample-point decode from the baud counter.
    always_comb begin
        tick_s = 1'b0;
        case (state_r)
            START:       tick_s = (cnt_r == HALF_M1);
            DATA, STOP:  tick_s = (cnt_r == FULL_M1);
            default:     tick_s = 1'b0;
        endcase
    end

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        shift_next_s = shift_r;
        case (state_r)
            IDLE: begin
                cnt_next_s = {CNT_W{1'b0}};
                idx_next_s = 3'd0;
                if (armed_r && !rx_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                // A line that returns high before mid-start is a glitch;
                // dropping out early keeps o_busy short for noise.
                if (rx_s) begin
                    state_next_s = IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else if (tick_s) begin
                    state_next_s = DATA;
                    cnt_next_s   = {CNT_W{1'b0}};
                    idx_next_s   = 3'd0;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_next_s[idx_r] = rx_s;
                    cnt_next_s          = {CNT_W{1'b0}};
                    if (idx_r == 3'd7) begin
                        state_next_s = STOP;
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (tick_s) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = rx_s ? IDLE : HOLD;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            HOLD: begin
                cnt_next_s = {CNT_W{1'b0}};
                if (rx_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
                idx_next_s   = 3'd0;
            end
        endcase
    end

    assign good_s = (state_r == STOP) && tick_s && rx_s;
    assign bad_s  = (state_r == STOP) && tick_s && !rx_s;

    // Holding register, handshake and status pulses.
    always_comb begin
        data_next_s      = data_r;
        valid_next_s     = valid_r;
        frame_err_next_s = bad_s;
        overrun_next_s   = 1'b0;
        if (good_s) begin
            if (!valid_r || i_rx_ack) begin
                data_next_s  = shift_r;
                valid_next_s = 1'b1;
            end else begin
                overrun_next_s = 1'b1;
            end
        end else if (valid_r && i_rx_ack) begin
            valid_next_s = 1'b0;
        end else begin
            valid_next_s = valid_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            idx_r       <= 3'd0;
            shift_r     <= {UART_DATA_W{1'b0}};
            data_r      <= {UART_DATA_W{1'b0}};
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            idx_r       <= idx_next_s;
            shift_r     <= shift_next_s;
            data_r      <= data_next_s;
            valid_r     <= valid_next_s;
            frame_err_r <= frame_err_next_s;
            overrun_r   <= overrun_next_s;
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign o_rx_data   = data_r;
    assign o_rx_valid  = valid_r;
    assign o_frame_err = frame_err_r;
    assign o_overrun   = overrun_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT = 16 with a 10 ns clock.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_rx = 1'b1;
    logic       i_rx_ack = 1'b0;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (i_rx),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .i_rx_ack    (i_rx_ack),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // Pulse widths accumulate here: a single one-cycle pulse adds exactly 1.
    always @(negedge clk) begin
        if (o_frame_err === 1'b1) fe_cnt++;
        if (o_overrun === 1'b1)   ov_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    // Drives start, 8 data bits LSB first, stop; returns 1 ns after an edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            i_rx = ~i_rx;
        end
        checks++; if (o_rx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", o_rx_data); end
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_rx_valid); end
        checks++; if (o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin errors++; $display("FAIL rst_pulses: got fe=%b ov=%b expected 0 0", o_frame_err, o_overrun); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
        // Release with the line already low: must not start a frame.
        i_rx = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (40) @(posedge clk); #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL low_at_release_busy: got %b expected 0", o_busy); end
        i_rx = 1'b1;
        repeat (5) @(posedge clk); #1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (154) @(posedge clk); #1;
                checks++; if (o_rx_valid !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL a5_before_latency: got valid=%b busy=%b expected 0 1", o_rx_valid, o_busy); end
                @(posedge clk); #1;
                checks++; if (o_rx_valid !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL a5_at_latency: got valid=%b busy=%b expected 1 0", o_rx_valid, o_busy); end
                checks++; if (o_rx_data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h expected a5", o_rx_data); end
            end
        join
        i_rx_ack = 1'b1;
        @(posedge clk); #1;
        i_rx_ack = 1'b0;
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL a5_ack: got %b expected 0", o_rx_valid); end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        @(posedge clk); #1;
        i_rx = 1'b0;
        repeat (5) @(posedge clk); #1;
        i_rx = 1'b1;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", o_busy); end
        repeat (4) @(posedge clk); #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0", o_busy); end
        repeat (200) @(posedge clk); #1;
        checks++; if (o_rx_valid !== 1'b0 || fe_cnt !== fe0) begin errors++; $display("FAIL glitch_no_output: got valid=%b fe=%0d expected 0 %0d", o_rx_valid, fe_cnt, fe0); end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        @(posedge clk); #1;
        send_frame(8'h3C, 1'b0);
        repeat (2 * CPB) @(posedge clk); #1;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ferr_hold_busy: got %b expected 1", o_busy); end
        i_rx = 1'b1;
        repeat (20) @(posedge clk); #1;
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles expected 1", fe_cnt - fe0); end
        checks++; if (o_rx_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL ferr_no_valid: got valid=%b busy=%b expected 0 0", o_rx_valid, o_busy); end
        send_frame(8'h81, 1'b1);
        checks++; if (o_rx_valid !== 1'b1 || o_rx_data !== 8'h81) begin errors++; $display("FAIL ferr_next_byte: got valid=%b data=%h expected 1 81", o_rx_valid, o_rx_data); end
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_no_extra: got %0d expected 1", fe_cnt - fe0); end
        i_rx_ack = 1'b1;
        @(posedge clk); #1;
        i_rx_ack = 1'b0;
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        @(posedge clk); #1;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ov_cnt - ov0); end
        checks++; if (o_rx_data !== 8'h11 || o_rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_keep_old: got data=%h valid=%b expected 11 1", o_rx_data, o_rx_valid); end
        i_rx_ack = 1'b1;
        @(posedge clk); #1;
        i_rx_ack = 1'b0;
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %b expected 0", o_rx_valid); end
    endtask

    task automatic test_back_to_back_ack();
        int ov0;
        ov0 = ov_cnt;
        @(posedge clk); #1;
        send_frame(8'h55, 1'b1);
        checks++; if (o_rx_data !== 8'h55 || o_rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got data=%h valid=%b expected 55 1", o_rx_data, o_rx_valid); end
        fork
            send_frame(8'hAA, 1'b1);
            begin
                repeat (154) @(posedge clk); #1;
                i_rx_ack = 1'b1;
                @(posedge clk); #1;
                i_rx_ack = 1'b0;
                checks++; if (o_rx_data !== 8'hAA || o_rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_simul_ack: got data=%h valid=%b expected aa 1", o_rx_data, o_rx_valid); end
            end
        join
        checks++; if (ov_cnt !== ov0 || o_rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_no_overrun: got ov=%0d valid=%b expected %0d 1", ov_cnt, o_rx_valid, ov0); end
        i_rx_ack = 1'b1;
        @(posedge clk); #1;
        i_rx_ack = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int fe0;
        int ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        @(posedge clk); #1;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                // Data bit 4 is frame bit 5: edges 80..95 after the start edge.
                repeat (88) @(posedge clk); #1;
                rst = 1'b0;
                #1;
                checks++; if (o_busy !== 1'b0 || o_rx_data !== 8'h00 || o_rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_clear: got busy=%b data=%h valid=%b expected 0 00 0", o_busy, o_rx_data, o_rx_valid); end
                @(posedge clk); #1;
                rst = 1'b1;
            end
        join
        repeat (20) @(posedge clk); #1;
        checks++; if (o_rx_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got valid=%b busy=%b expected 0 0", o_rx_valid, o_busy); end
        send_frame(8'h0F, 1'b1);
        checks++; if (o_rx_data !== 8'h0F || o_rx_valid !== 1'b1) begin errors++; $display("FAIL midrst_next: got data=%h valid=%b expected 0f 1", o_rx_data, o_rx_valid); end
        checks++; if (fe_cnt !== fe0 || ov_cnt !== ov0) begin errors++; $display("FAIL midrst_pulses: got fe=%0d ov=%0d expected %0d %0d", fe_cnt, ov_cnt, fe0, ov0); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back_ack();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the lab UART: recovers 8N1 frames from the `i_rx` line and presents each byte through a one-entry holding register with a valid/acknowledge handshake. It is the receive half matching the transmitter inside `uart_top`. `uart_top` instantiates it to drive `o_rx_data` and `o_rx_valid`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Legal range is 4 or more; even values only.
- `SYNC_STAGES`, default 2: flops in the `i_rx` metastability synchronizer.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset, asynchronous assert, active-low. Clock and reset are single-domain: one clock, `rst` is asynchronous and active-low.
- `i_rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `o_rx_data`  output  8  last received byte, LSB first on the wire.
- `o_rx_valid`  output  1  high while `o_rx_data` holds an unconsumed byte.
- `i_rx_ack`  input  1  consumer accepts the byte. Effective only when `o_rx_valid` is 1.
- `o_frame_err`  output  1  one-cycle pulse: the stop bit sampled low.
- `o_overrun`  output  1  one-cycle pulse: a byte completed while `o_rx_valid` was still 1.
- `o_busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- `i_rx` passes through `SYNC_STAGES` flops. Each synchronizer flop resets to 1. The FSM sees only the synchronized value, `rx_s`.
- FSM states and transitions:
  - IDLE → START when `rx_s` is 0.
  - START: wait `CLKS_PER_BIT/2` cycles, then sample at mid-start. If `rx_s` is 1, treat it as a glitch and return to IDLE with no output. Otherwise go to DATA with the bit index at 0.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit [index]. After index 7, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample the stop bit.
    - Stop bit 1: the frame is good.
    - Stop bit 0: pulse `o_frame_err`, discard the byte, and wait in IDLE-entry hold until `rx_s` is 1. This blocks break conditions from re-triggering.
    - Either way, the next state is IDLE, or the hold described above.
- Good frame handling:
  - If `o_rx_valid` is 0, load `o_rx_data` and set `o_rx_valid`.
  - If `o_rx_valid` is 1 and `i_rx_ack` is not 1 in the same cycle, pulse `o_overrun`, drop the new byte, and keep the old data.
  - If `o_rx_valid` and `i_rx_ack` are both 1 in the completion cycle, the ack frees the register and the new byte loads. `o_rx_valid` stays 1 and there is no overrun.
- Otherwise, `i_rx_ack` while `o_rx_valid` is 1 clears `o_rx_valid` on the next edge. Ack while not valid is ignored.
- Counters:
  - Baud counter width is `$clog2(CLKS_PER_BIT)`. It reloads to 0 at each sample point and never wraps past `CLKS_PER_BIT-1`.
  - Bit index is 3 bits.
- Reset mid-frame: all state returns immediately to the reset values. The partial byte is lost. After `rst` releases, the receiver waits for a 1-to-0 transition in IDLE. A line already low at reset release is ignored until it returns high.

## Timing
- Reset values:
  - `o_rx_data` = 8'h00
  - `o_rx_valid` = 0
  - `o_frame_err` = 0
  - `o_overrun` = 0
  - `o_busy` = 0
  - FSM in IDLE
- Sample points are `CLKS_PER_BIT/2 + k*CLKS_PER_BIT` cycles after `rx_s` falls, for k = 0 (start) through 9 (stop).
- `o_rx_valid` rises 1 cycle after the stop sample. Total latency from the `i_rx` falling edge is `SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1` cycles.
- `o_frame_err` and `o_overrun` are each exactly 1 cycle wide, aligned with the cycle in which `o_rx_valid` would have risen.
- `o_busy` falls in the same cycle `o_rx_valid` rises. Back-to-back frames are accepted with a stop bit of exactly 1 bit time.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, HOLD.
  - `UART_DATA_W` = 8
  - default `CLKS_PER_BIT`
  - The same constants are used by the transmitter.
- One natural sub-module: `uart_sync`, the parameterized N-flop synchronizer with a configurable reset value. It is reused for other asynchronous inputs.

## Test plan
Bench uses `CLKS_PER_BIT` = 16, 10 ns clock.
- Reset behaviour: hold `rst` = 0 with `i_rx` toggling → all outputs at reset values. Release reset, then send 8'hA5 → `o_rx_data` = 8'hA5 and `o_rx_valid` = 1, exactly at the latency given in Timing.
- Glitch rejection: drive `i_rx` low for 5 cycles, then high → no valid, no error, and `o_busy` returns to 0 before the mid-start sample point.
- Framing error: send 8'h3C with the stop bit 0, holding the line low 2 more bit times → one `o_frame_err` pulse and no valid. A following 8'h81 is received correctly.
- Overrun: send 8'h11 with no ack, then 8'h22 → one `o_overrun` pulse and `o_rx_data` stays 8'h11. Ack → `o_rx_valid` falls the next cycle.
- Simultaneous ack and completion: send 8'h55, then 8'hAA, asserting `i_rx_ack` exactly in the 8'hAA completion cycle → `o_rx_data` = 8'hAA, `o_rx_valid` stays 1, no overrun.
- Reset mid-frame: assert `rst` during data bit 4 of 8'hF0 → state clears immediately. The next frame, 8'h0F, is received correctly.
